// File: rtl/rvm_pcu.sv
// rtl/rvm_pcu.sv - program counter unit with instruction fetch state machine
//
// Owns the architectural PC and sequences instruction fetches:
// FETCH (request) -> WAIT (response / timeout) -> EXEC (hand word to execute)
// with a one-cycle TRAP state for fetch faults and misaligned transfers.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   imem_req/addr/gnt          fetch request channel
//   imem_rvalid/rdata/err      fetch response channel
//   instr_valid, instr         fetched word presented to execute
//   exec_done, branch_taken,
//   branch_target, mret        execute completion and next-PC selection
//   goto_mtvec, mtvec, mepc    trap redirect inputs from the system control unit
//   pc, instr_retired          architectural PC and retire pulse
//   trap_iaddr_misalign,
//   trap_iaddr_fault,
//   ld_bad_addr, bad_addr_val  trap reporting to the system control unit

module rvm_pcu #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mret,
    input  logic        goto_mtvec,
    input  logic [29:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] pc,
    output logic        instr_retired,
    output logic        trap_iaddr_misalign,
    output logic        trap_iaddr_fault,
    output logic        ld_bad_addr,
    output logic [31:0] bad_addr_val
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    // Count value of the last WAIT cycle before the fetch is declared lost.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] bad_q, bad_nxt;
    logic        fault_q, fault_nxt;   // 1: access fault, 0: misaligned target
    logic        retire;
    logic [31:0] target;
    logic        redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= 8'd0;
            instr_q <= 32'd0;
            bad_q   <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            cnt_q   <= cnt_nxt;
            instr_q <= instr_nxt;
            bad_q   <= bad_nxt;
            fault_q <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        instr_nxt = instr_q;
        bad_nxt   = bad_q;
        fault_nxt = fault_q;
        retire    = 1'b0;
        redirect  = mret | branch_taken;
        target    = mret ? mepc : (branch_taken ? branch_target : pc_q + 32'd4);

        case (state)
            S_FETCH: begin
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 8'd0;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt_q + 8'd1;
                // A response arriving on the timeout cycle takes precedence.
                if (imem_rvalid && !imem_err) begin
                    instr_nxt = imem_rdata;
                    state_nxt = S_EXEC;
                end else if (imem_rvalid || cnt_q == TMO_LAST) begin
                    bad_nxt   = pc_q;
                    fault_nxt = 1'b1;
                    state_nxt = S_TRAP;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (goto_mtvec) begin
                        pc_nxt    = {mtvec, 2'b00};
                        state_nxt = S_FETCH;
                    end else if (redirect && target[1:0] != 2'b00) begin
                        // pc stays on the offending instruction so it becomes mepc.
                        bad_nxt   = target;
                        fault_nxt = 1'b0;
                        state_nxt = S_TRAP;
                    end else begin
                        pc_nxt    = target;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                pc_nxt    = {mtvec, 2'b00};
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Everything except the PC is forced low while reset is held.
    assign pc                  = pc_q;
    assign imem_addr           = pc_q;
    assign imem_req            = !reset && state == S_FETCH;
    assign instr_valid         = !reset && state == S_EXEC;
    assign instr               = reset ? 32'd0 : instr_q;
    assign instr_retired       = !reset && retire;
    assign ld_bad_addr         = !reset && state == S_TRAP;
    assign trap_iaddr_fault    = !reset && state == S_TRAP && fault_q;
    assign trap_iaddr_misalign = !reset && state == S_TRAP && !fault_q;
    assign bad_addr_val        = reset ? 32'd0 : bad_q;

endmodule

// File: tb/tb_rvm_pcu.sv
// tb/tb_rvm_pcu.sv - scoreboard testbench for rvm_pcu
module tb_rvm_pcu;

    localparam int K_FETCH = 0, K_EXEC = 1, K_MIS = 2, K_FLT = 3, K_RET = 4, K_BAD = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic        exec_done = 1'b0, branch_taken = 1'b0, mret = 1'b0, goto_mtvec = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [29:0] mtvec = 30'h70;          // vector 0x1C0
    logic [31:0] mepc = 32'h80;
    logic [31:0] pc;
    logic        instr_retired, trap_iaddr_misalign, trap_iaddr_fault, ld_bad_addr;
    logic [31:0] bad_addr_val;

    rvm_pcu #(.RESET_VECTOR(32'h0), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr_valid(instr_valid), .instr(instr),
        .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
        .mret(mret), .goto_mtvec(goto_mtvec), .mtvec(mtvec), .mepc(mepc),
        .pc(pc), .instr_retired(instr_retired),
        .trap_iaddr_misalign(trap_iaddr_misalign), .trap_iaddr_fault(trap_iaddr_fault),
        .ld_bad_addr(ld_bad_addr), .bad_addr_val(bad_addr_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          c;   // cycles since last grant, -1 = not checked
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- memory model ----------------
    int          mem_lat = 2;
    logic        mem_err = 1'b0;
    logic        mem_noresp = 1'b0;
    int          pending = -1;
    logic [31:0] lat_addr = 32'd0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_err    = 1'b0;
            if (reset) begin
                pending = -1;
            end else begin
                if (pending == 0) begin
                    if (!mem_noresp) begin
                        imem_rvalid = 1'b1;
                        imem_err    = mem_err;
                        imem_rdata  = mem_word(lat_addr);
                    end
                    pending = -1;
                end else if (pending > 0) begin
                    pending--;
                end
                if (imem_req) begin
                    imem_gnt = 1'b1;
                    lat_addr = imem_addr;
                    pending  = mem_lat - 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   last_gnt = 0;
    logic prev_iv = 1'b0;

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] b, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d a %h b %h with nothing expected", k, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a ||
                ((k == K_MIS || k == K_FLT) && e.b !== b) ||
                (e.c >= 0 && e.c != c)) begin
                errors++;
                $display("FAIL event: got kind %0d a %h b %h dt %0d, expected kind %0d a %h b %h dt %0d",
                         k, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                observe(K_FETCH, imem_addr, 32'd0, -1);
                last_gnt = cyc;
            end
            if (instr_valid && !prev_iv)
                observe(K_EXEC, instr, 32'd0, cyc - last_gnt);
            if (instr_retired)
                observe(K_RET, pc, 32'd0, -1);
            if (ld_bad_addr || trap_iaddr_misalign || trap_iaddr_fault) begin
                if (ld_bad_addr && trap_iaddr_misalign && !trap_iaddr_fault)
                    observe(K_MIS, bad_addr_val, pc, cyc - last_gnt);
                else if (ld_bad_addr && trap_iaddr_fault && !trap_iaddr_misalign)
                    observe(K_FLT, bad_addr_val, pc, cyc - last_gnt);
                else
                    observe(K_BAD, bad_addr_val, pc, cyc - last_gnt);
            end
        end
        prev_iv = instr_valid;
    end

    // ---------------- stimulus ----------------
    task automatic wait_iv();
        for (int i = 0; i < 60; i++) begin
            if (instr_valid) break;
            @(posedge clk); #1;
        end
        chk("wait_instr_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_trap();
        for (int i = 0; i < 60; i++) begin
            if (ld_bad_addr) break;
            @(posedge clk); #1;
        end
        chk("wait_trap", {31'd0, ld_bad_addr}, 32'd1);
    endtask

    task automatic exec(input logic g, input logic m, input logic br, input logic [31:0] tgt);
        wait_iv();
        exec_done     = 1'b1;
        goto_mtvec    = g;
        mret          = m;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk); #1;
        exec_done     = 1'b0;
        goto_mtvec    = 1'b0;
        mret          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_traps", {29'd0, ld_bad_addr, trap_iaddr_fault, trap_iaddr_misalign}, 32'd0);
        chk("rst_retired", {31'd0, instr_retired}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_bad_addr", bad_addr_val, 32'h0);

        // sequential fetch and retire
        push(K_FETCH, 32'h0, 0, -1);
        push(K_EXEC, mem_word(32'h0), 0, 3);
        push(K_RET, 32'h0, 0, -1);
        push(K_FETCH, 32'h4, 0, -1);
        push(K_EXEC, mem_word(32'h4), 0, 3);
        reset = 1'b0;
        exec(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pc_after_retire", pc, 32'h4);

        // misaligned branch
        push(K_MIS, 32'h102, 32'h4, -1);
        push(K_FETCH, 32'h1C0, 0, -1);
        push(K_EXEC, mem_word(32'h1C0), 0, 3);
        exec(1'b0, 1'b0, 1'b1, 32'h102);
        chk("pc_holds_in_trap", pc, 32'h4);

        // bus error on fetch at 0x40
        push(K_RET, 32'h1C0, 0, -1);
        push(K_FETCH, 32'h40, 0, -1);
        push(K_FLT, 32'h40, 32'h40, 3);
        push(K_FETCH, 32'h1C0, 0, -1);
        push(K_EXEC, mem_word(32'h1C0), 0, 3);
        wait_iv();
        mem_err = 1'b1;
        exec(1'b0, 1'b0, 1'b1, 32'h40);
        wait_trap();
        mem_err = 1'b0;

        // timeout, then a response on the last allowed cycle
        push(K_RET, 32'h1C0, 0, -1);
        push(K_FETCH, 32'h200, 0, -1);
        push(K_FLT, 32'h200, 32'h200, 5);
        push(K_FETCH, 32'h1C0, 0, -1);
        push(K_EXEC, mem_word(32'h1C0), 0, 5);
        wait_iv();
        mem_noresp = 1'b1;
        exec(1'b0, 1'b0, 1'b1, 32'h200);
        wait_trap();
        mem_noresp = 1'b0;
        mem_lat = 4;
        wait_iv();
        mem_lat = 2;

        // goto_mtvec beats mret, then mret alone
        push(K_FETCH, 32'h1C0, 0, -1);
        push(K_EXEC, mem_word(32'h1C0), 0, 3);
        push(K_RET, 32'h1C0, 0, -1);
        push(K_FETCH, 32'h80, 0, -1);
        push(K_EXEC, mem_word(32'h80), 0, 3);
        exec(1'b1, 1'b1, 1'b0, 32'h0);
        exec(1'b0, 1'b1, 1'b0, 32'h0);

        // PC wrap
        push(K_RET, 32'h80, 0, -1);
        push(K_FETCH, 32'hFFFF_FFFC, 0, -1);
        push(K_EXEC, mem_word(32'hFFFF_FFFC), 0, 3);
        push(K_RET, 32'hFFFF_FFFC, 0, -1);
        push(K_FETCH, 32'h0, 0, -1);
        push(K_EXEC, mem_word(32'h0), 0, 3);
        exec(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exec(1'b0, 1'b0, 1'b0, 32'h0);

        // reset while waiting for a response
        push(K_RET, 32'h0, 0, -1);
        push(K_FETCH, 32'h4, 0, -1);
        push(K_FETCH, 32'h0, 0, -1);
        push(K_EXEC, mem_word(32'h0), 0, 3);
        exec(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("midreset_pc", pc, 32'h0);
        chk("midreset_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        wait_iv();
        repeat (4) begin @(posedge clk); #1; end
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
